// File: rtl/artemis_rst_seq_pkg.sv
// Shared state encoding, output bundle and default timing constants for the
// DDR3 PLL reset sequencer.
package artemis_rst_seq_pkg;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_t;

  typedef struct packed {
    logic pll_rst;
    logic ddr3_rst;
    logic ready;
  } rst_outs_t;

  // Moore output decode, applied to the next state so the outputs stay registered.
  function automatic rst_outs_t state_outs(input rst_state_t s);
    rst_outs_t o;
    o = '{pll_rst: 1'b1, ddr3_rst: 1'b1, ready: 1'b0};
    case (s)
      ST_PLL_RST:   o = '{pll_rst: 1'b1, ddr3_rst: 1'b1, ready: 1'b0};
      ST_WAIT_LOCK: o = '{pll_rst: 1'b0, ddr3_rst: 1'b1, ready: 1'b0};
      ST_STABLE:    o = '{pll_rst: 1'b0, ddr3_rst: 1'b1, ready: 1'b0};
      ST_RUN:       o = '{pll_rst: 1'b0, ddr3_rst: 1'b0, ready: 1'b1};
      default:      o = '{pll_rst: 1'b1, ddr3_rst: 1'b1, ready: 1'b0};
    endcase
    return o;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/artemis_sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-low clear.
module artemis_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Fewer than two flops gives no metastability margin, so clamp upward.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[N-2:0], d};
    end
  end

  assign q = sync_ff[N-1];

endmodule

// File: rtl/artemis_ddr3_rst_seq.sv
// DDR3 PLL reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the DDR3 domain; retries on lock timeout or loss of lock.
module artemis_ddr3_rst_seq
  import artemis_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       ddr3_rst,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam int MAX_CYCLES = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

  // The counter holds remaining cycles minus one, so it reaches zero on the
  // last cycle of a state and the largest count fits in clog2 bits.
  localparam logic [CNT_W-1:0] PLL_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic             lock_s;
  rst_state_t       state;
  logic [CNT_W-1:0] cnt;
  rst_outs_t        outs;

  artemis_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // force_reset is checked first so it overrides any lock-driven transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PLL_RST;
      cnt          <= PLL_LOAD;
      outs         <= state_outs(ST_PLL_RST);
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
    end else if (force_reset) begin
      state <= ST_PLL_RST;
      cnt   <= PLL_LOAD;
      outs  <= state_outs(ST_PLL_RST);
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == '0) begin
            state <= ST_WAIT_LOCK;
            cnt   <= TIMEOUT_LOAD;
            outs  <= state_outs(ST_WAIT_LOCK);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= STABLE_LOAD;
            outs  <= state_outs(ST_STABLE);
          end else if (cnt == '0) begin
            state       <= ST_PLL_RST;
            cnt         <= PLL_LOAD;
            outs        <= state_outs(ST_PLL_RST);
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // Any dropout restarts the stability window from scratch.
        ST_STABLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= TIMEOUT_LOAD;
            outs  <= state_outs(ST_WAIT_LOCK);
          end else if (cnt == '0) begin
            state       <= ST_RUN;
            cnt         <= PLL_LOAD;
            outs        <= state_outs(ST_RUN);
            timeout_err <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state <= ST_PLL_RST;
            cnt   <= PLL_LOAD;
            outs  <= state_outs(ST_PLL_RST);
            if (relock_count != 8'hFF) begin
              relock_count <= relock_count + 8'd1;
            end
          end
        end

        default: begin
          state <= ST_PLL_RST;
          cnt   <= PLL_LOAD;
          outs  <= state_outs(ST_PLL_RST);
        end
      endcase
    end
  end

  assign pll_rst  = outs.pll_rst;
  assign ddr3_rst = outs.ddr3_rst;
  assign ready    = outs.ready;

endmodule

// File: tb/tb_artemis_ddr3_rst_seq.sv
// Directed bench for artemis_ddr3_rst_seq with short timing parameters;
// expected values are hand-derived cycle counts from each stimulus point.
module tb_artemis_ddr3_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       force_reset = 1'b0;
  logic       pll_rst;
  logic       ddr3_rst;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  artemis_ddr3_rst_seq #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_reset  (force_reset),
    .pll_rst      (pll_rst),
    .ddr3_rst     (ddr3_rst),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lock, input logic frc);
    pll_locked  = lock;
    force_reset = frc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    checkOutput({tag, "_ddr3_rst"}, 32'(ddr3_rst), 32'd1);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
    checkOutput({tag, "_relock"}, 32'(relock_count), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
    tick(2);
    checkResetValues("reset");

    // Release reset: four cycles of PLL reset, lock still absent.
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checkOutput($sformatf("pll_rst_hold_%0d", k), 32'(pll_rst), 32'(k < 4));
    end
    checkOutput("ready_after_pll_rst", 32'(ready), 32'd0);

    // Lock rises 3 cycles after pll_rst falls; release lands 2+1+8 cycles later.
    tick(3);
    applyStimulus(1'b1, 1'b0);
    tick(10);
    checkOutput("ready_before_release", 32'(ready), 32'd0);
    checkOutput("ddr3_before_release", 32'(ddr3_rst), 32'd1);
    tick(1);
    checkOutput("ready_at_release", 32'(ready), 32'd1);
    checkOutput("ddr3_at_release", 32'(ddr3_rst), 32'd0);
    checkOutput("relock_first_run", 32'(relock_count), 32'd0);

    // One-cycle lock loss in RUN.
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("ready_loss_plus2", 32'(ready), 32'd1);
    tick(1);
    checkOutput("ready_loss_plus3", 32'(ready), 32'd0);
    checkOutput("ddr3_loss_plus3", 32'(ddr3_rst), 32'd1);
    checkOutput("pll_rst_loss_plus3", 32'(pll_rst), 32'd1);
    checkOutput("relock_after_loss", 32'(relock_count), 32'd1);
    tick(3);
    checkOutput("pll_rst_loss_last", 32'(pll_rst), 32'd1);
    tick(1);
    checkOutput("pll_rst_loss_end", 32'(pll_rst), 32'd0);
    tick(9);
    checkOutput("ready_relocked", 32'(ready), 32'd1);

    // force_reset coincident with lock loss in RUN: no relock increment.
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("force_loss_ready", 32'(ready), 32'd0);
    checkOutput("force_loss_pll_rst", 32'(pll_rst), 32'd1);
    checkOutput("force_loss_relock", 32'(relock_count), 32'd1);
    tick(13);
    checkOutput("force_loss_rerun", 32'(ready), 32'd1);
    checkOutput("force_loss_relock_run", 32'(relock_count), 32'd1);

    // Lock dropout while STABLE counter is at 5 restarts the full window.
    applyStimulus(1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("force_ready", 32'(ready), 32'd0);
    tick(5);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(10);
    checkOutput("stable_restart_wait", 32'(ready), 32'd0);
    tick(1);
    checkOutput("stable_restart_ready", 32'(ready), 32'd1);
    checkOutput("stable_restart_ddr3", 32'(ddr3_rst), 32'd0);

    // Repeated lock losses saturate relock_count.
    for (int i = 0; i < 299; i++) begin
      applyStimulus(1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b1, 1'b0);
      tick(15);
      if (i == 9) checkOutput("relock_mid", 32'(relock_count), 32'd11);
    end
    checkOutput("relock_saturated", 32'(relock_count), 32'd255);
    checkOutput("ready_after_loop", 32'(ready), 32'd1);

    // Lock never arrives: 32 WAIT_LOCK cycles then a retry with timeout_err.
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("to_pll_rst_start", 32'(pll_rst), 32'd1);
    checkOutput("to_relock_kept", 32'(relock_count), 32'd255);
    tick(4);
    checkOutput("to_wait_entry", 32'(pll_rst), 32'd0);
    tick(31);
    checkOutput("to_wait_last", 32'(pll_rst), 32'd0);
    checkOutput("to_err_before", 32'(timeout_err), 32'd0);
    tick(1);
    checkOutput("to_retry_pll_rst", 32'(pll_rst), 32'd1);
    checkOutput("to_err_set", 32'(timeout_err), 32'd1);
    tick(3);
    checkOutput("to_retry_hold", 32'(pll_rst), 32'd1);
    tick(1);
    checkOutput("to_retry_end", 32'(pll_rst), 32'd0);
    applyStimulus(1'b1, 1'b0);
    tick(10);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
    checkOutput("to_ready_wait", 32'(ready), 32'd0);
    tick(1);
    checkOutput("to_ready_run", 32'(ready), 32'd1);
    checkOutput("to_err_cleared", 32'(timeout_err), 32'd0);

    // Asynchronous reset between edges, then a full restart.
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    tick(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checkOutput($sformatf("rerst_pll_rst_%0d", k), 32'(pll_rst), 32'(k < 4));
    end
    tick(8);
    checkOutput("rerst_ready_wait", 32'(ready), 32'd0);
    tick(1);
    checkOutput("rerst_ready_run", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
